// File: rtl/mem_lsu.sv
// Load/store unit in front of the word-wide data memory: sizing, extension, alignment, sub-word RMW.
// Optional MEM_LSU_ERRCNT_EN adds a saturating err_cnt output counting error responses.
module mem_lsu #(
    parameter int BIG_ENDIAN = 0,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_uns,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
`ifdef MEM_LSU_ERRCNT_EN
    output logic [15:0]       err_cnt,
`endif
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_ctrl_w,
    output logic              dm_ctrl_r,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    typedef enum logic [1:0] {IDLE, ACC, RMW_RD, RMW_WR} state_e;

    localparam logic BE = (BIG_ENDIAN != 0);

    state_e              state_q, state_d;
    logic                we_q, uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         wbuf_q, wbuf_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;

    logic                accept, misal;
    logic [1:0]          blane;
    logic                hlane;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [31:0]         ld_ext;

    assign accept = req_valid && req_ready;

    always_comb begin
        misal = 1'b0;
        case (req_size)
            2'b00:   misal = 1'b0;
            2'b01:   misal = req_addr[0];
            2'b10:   misal = (req_addr[1:0] != 2'b00);
            default: misal = 1'b1;
        endcase
    end

    // Lane indices are flipped for big-endian so addr 0 maps to the top byte.
    assign blane = BE ? ~addr_q[1:0] : addr_q[1:0];
    assign hlane = BE ? ~addr_q[1] : addr_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !misal)
                    state_d = (req_we && req_size != 2'b10) ? RMW_RD : ACC;
            end
            ACC:     state_d = IDLE;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        dm_ctrl_r = 1'b0;
        dm_ctrl_w = 1'b0;
        dm_wdata  = '0;
        dm_addr   = '0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            ACC: begin
                dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
                dm_ctrl_r = !we_q;
                dm_ctrl_w = we_q;
                dm_wdata  = we_q ? wdata_q : 32'h0;
            end
            RMW_RD: begin
                dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
                dm_ctrl_r = 1'b1;
            end
            RMW_WR: begin
                dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
                dm_ctrl_w = 1'b1;
                dm_wdata  = wbuf_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = 8'h0;
        case (blane)
            2'd0: ld_byte = dm_rdata[7:0];
            2'd1: ld_byte = dm_rdata[15:8];
            2'd2: ld_byte = dm_rdata[23:16];
            2'd3: ld_byte = dm_rdata[31:24];
            default: ;
        endcase
        ld_half = hlane ? dm_rdata[31:16] : dm_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h0, ld_byte}
                                    : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = uns_q ? {16'h0, ld_half}
                                    : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    always_comb begin
        wbuf_d = dm_rdata;
        if (size_q == 2'b00) begin
            case (blane)
                2'd0: wbuf_d[7:0]   = wdata_q[7:0];
                2'd1: wbuf_d[15:8]  = wdata_q[7:0];
                2'd2: wbuf_d[23:16] = wdata_q[7:0];
                2'd3: wbuf_d[31:24] = wdata_q[7:0];
                default: ;
            endcase
        end else if (hlane) begin
            wbuf_d[31:16] = wdata_q[15:0];
        end else begin
            wbuf_d[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept && misal) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                end
            end
            ACC: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? 32'h0 : ld_ext;
            end
            RMW_WR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            wbuf_q       <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_uns;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == RMW_RD) wbuf_q <= wbuf_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

`ifdef MEM_LSU_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= 16'h0;
        else if (resp_valid_q && resp_err_q && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a small behavioural word memory.
// Build with MEM_LSU_ERRCNT_EN defined to also check err_cnt.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
`ifdef MEM_LSU_ERRCNT_EN
    logic [15:0] err_cnt;
`endif
    logic [31:0] dm_addr;
    logic        dm_ctrl_w, dm_ctrl_r;
    logic [31:0] dm_wdata, dm_rdata;

    logic [31:0] mem [16];

    int errors = 0;
    int checks = 0;

    int          r_lat, r_rd, r_wr;
    logic        r_both, r_err;
    logic [31:0] r_rdata;

    always #5 clk = ~clk;

    mem_lsu #(.BIG_ENDIAN(0), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_uns(req_uns),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
`ifdef MEM_LSU_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .dm_addr(dm_addr), .dm_ctrl_w(dm_ctrl_w), .dm_ctrl_r(dm_ctrl_r),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    assign dm_rdata = mem[dm_addr[5:2]];

    always @(posedge clk) begin
        if (dm_ctrl_w) mem[dm_addr[5:2]] <= dm_wdata;
    end

    // Issues one request and follows it to its response, noting latency and dm strobes.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        req_we = we; req_size = sz; req_uns = uns;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_lat = 1; r_rd = 0; r_wr = 0; r_both = 1'b0;
        while (!resp_valid && r_lat < 8) begin
            if (dm_ctrl_r && r_rd == 0) r_rd = r_lat;
            if (dm_ctrl_w && r_wr == 0) r_wr = r_lat;
            if (dm_ctrl_r && dm_ctrl_w) r_both = 1'b1;
            @(posedge clk); #1;
            r_lat++;
        end
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL timeout: no resp_valid for addr %h", a);
        end
        r_err = resp_err;
        r_rdata = resp_rdata;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready: got %b want 1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_err, dm_ctrl_w, dm_ctrl_r} !== 4'b0) begin
            errors++;
            $display("FAIL rst_flags: got %b want 0000",
                     {resp_valid, resp_err, dm_ctrl_w, dm_ctrl_r});
        end
        checks++;
        if ({resp_rdata, dm_addr, dm_wdata} !== 96'h0) begin
            errors++;
            $display("FAIL rst_data: got %h %h %h want 0", resp_rdata, dm_addr, dm_wdata);
        end
`ifdef MEM_LSU_ERRCNT_EN
        checks++;
        if (err_cnt !== 16'h0) begin
            errors++; $display("FAIL rst_errcnt: got %h want 0", err_cnt);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word;
        do_req(1'b1, 2'b10, 1'b0, 32'd4, 32'h11223344);
        checks++;
        if (r_lat !== 2) begin
            errors++; $display("FAIL sw_lat: got %0d want 2", r_lat);
        end
        checks++;
        if (mem[1] !== 32'h11223344) begin
            errors++; $display("FAIL sw_mem: got %h want 11223344", mem[1]);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
        checks++;
        if (r_lat !== 2) begin
            errors++; $display("FAIL lw_lat: got %0d want 2", r_lat);
        end
        checks++;
        if ({r_err, r_rdata} !== {1'b0, 32'h11223344}) begin
            errors++; $display("FAIL lw_data: got %b %h want 0 11223344", r_err, r_rdata);
        end
    endtask

    task automatic test_subword;
        do_req(1'b0, 2'b00, 1'b0, 32'd6, 32'h0);
        checks++;
        if (r_rdata !== 32'h00000022) begin
            errors++; $display("FAIL lb6: got %h want 00000022", r_rdata);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'd6, 32'h0);
        checks++;
        if (r_rdata !== 32'h00001122) begin
            errors++; $display("FAIL lh6: got %h want 00001122", r_rdata);
        end
        do_req(1'b1, 2'b00, 1'b0, 32'd5, 32'hFFFFFF80);
        checks++;
        if (mem[1] !== 32'h11228044) begin
            errors++; $display("FAIL sb5_mem: got %h want 11228044", mem[1]);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'd5, 32'h0);
        checks++;
        if (r_rdata !== 32'hFFFFFF80) begin
            errors++; $display("FAIL lb5: got %h want ffffff80", r_rdata);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'd5, 32'h0);
        checks++;
        if (r_rdata !== 32'h00000080) begin
            errors++; $display("FAIL lbu5: got %h want 00000080", r_rdata);
        end
    endtask

    task automatic test_rmw;
        do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'h00000080);
        do_req(1'b1, 2'b00, 1'b0, 32'd9, 32'h000000AB);
        checks++;
        if (r_lat !== 3) begin
            errors++; $display("FAIL sb_lat: got %0d want 3", r_lat);
        end
        checks++;
        if (r_rd !== 1 || r_wr !== 2 || r_both !== 1'b0) begin
            errors++;
            $display("FAIL sb_seq: got rd@%0d wr@%0d both=%b want rd@1 wr@2 both=0",
                     r_rd, r_wr, r_both);
        end
        checks++;
        if (mem[2] !== 32'h0000AB80) begin
            errors++; $display("FAIL sb_mem: got %h want 0000ab80", mem[2]);
        end
        checks++;
        if ({r_err, r_rdata} !== 33'h0) begin
            errors++; $display("FAIL sb_resp: got %b %h want 0 0", r_err, r_rdata);
        end
    endtask

    task automatic test_misaligned;
        logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad [3] = '{32'd2, 32'd3, 32'd0};
        for (int i = 0; i < 3; i++) begin
            do_req(i == 1, sz[i], 1'b0, ad[i], 32'hDEADBEEF);
            checks++;
            if (r_lat !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
                errors++;
                $display("FAIL misal%0d: got lat=%0d err=%b data=%h want 1 1 0",
                         i, r_lat, r_err, r_rdata);
            end
            checks++;
            if (r_rd !== 0 || r_wr !== 0) begin
                errors++;
                $display("FAIL misal%0d_dm: got rd@%0d wr@%0d want none", i, r_rd, r_wr);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: got valid=%b err=%b want 0 1", resp_valid, resp_err);
        end
`ifdef MEM_LSU_ERRCNT_EN
        checks++;
        if (err_cnt !== 16'd3) begin
            errors++; $display("FAIL errcnt: got %0d want 3", err_cnt);
        end
`endif
    endtask

    task automatic test_reset_abort;
        logic saw;
        do_req(1'b1, 2'b10, 1'b0, 32'd0, 32'hCAFEF00D);
        req_we = 1'b1; req_size = 2'b01; req_uns = 1'b0;
        req_addr = 32'd0; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (dm_ctrl_r !== 1'b1) begin
            errors++; $display("FAIL abort_rd: got %b want 1", dm_ctrl_r);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dm_ctrl_r, dm_ctrl_w, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL abort_async: got %b want 001", {dm_ctrl_r, dm_ctrl_w, req_ready});
        end
        saw = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            saw |= resp_valid | dm_ctrl_w;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            saw |= resp_valid | dm_ctrl_w;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++; $display("FAIL abort_quiet: got activity=%b want 0", saw);
        end
        checks++;
        if (mem[0] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL abort_mem: got %h want cafef00d", mem[0]);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp [3] = '{32'hCAFEF00D, 32'h11228044, 32'h0000AB80};
        int   k, j;
        logic rdy;
        k = 0; j = 0;
        req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0;
        req_addr = 32'd0; req_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy && k < 3) begin
                k++;
                if (k == 3) req_valid = 1'b0;
                else        req_addr = 32'(4 * k);
            end
            if (resp_valid) begin
                checks++;
                if (j > 2) begin
                    errors++; $display("FAIL b2b_extra: got resp %0d want 3 total", j);
                end else if (resp_rdata !== exp[j] || c !== 2 * (j + 1)) begin
                    errors++;
                    $display("FAIL b2b%0d: got %h @%0d want %h @%0d",
                             j, resp_rdata, c, exp[j], 2 * (j + 1));
                end
                j++;
            end
        end
        checks++;
        if (j !== 3) begin
            errors++; $display("FAIL b2b_count: got %0d want 3", j);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_rmw();
        test_misaligned();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of the word-wide data memory `dm`.
- Accepts one load or store per request from the MEM stage and handles byte/halfword/word sizing, sign/zero extension and alignment checking.
- Sub-word stores are performed as read-modify-write, since `dm` only reads and writes full 32-bit words.
- Drives `dm` through its native addr/ctrl_w/ctrl_r/wdata/rdata interface.

Parameters:
- BIG_ENDIAN, 0: byte-lane order. 0 = addr[1:0]==0 selects bits [7:0]; 1 = addr[1:0]==0 selects bits [31:24].
- ADDR_W, 32: width of the byte address.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- req_uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualified by resp_valid; misaligned or illegal size
- resp_rdata  out  32  extended load data; 0 for stores and errors
- dm_addr  out  ADDR_W  word address to `dm`, low 2 bits forced to 0
- dm_ctrl_w  out  1  `dm` write enable; `dm` writes at the rising edge
- dm_ctrl_r  out  1  `dm` read enable; dm_rdata valid combinationally in the same cycle
- dm_wdata  out  32  word to write
- dm_rdata  in  32  word read from `dm`

Behaviour:
- Reset: state=IDLE. req_ready=1; resp_valid, resp_err, resp_rdata, dm_ctrl_w, dm_ctrl_r, dm_wdata, dm_addr all 0.
- dm_* outputs decode combinationally from state and latched registers, so reset drops dm_ctrl_w and dm_ctrl_r immediately.
- Accept occurs on a rising edge with req_valid && req_ready. At accept, latch we, size, uns, addr and wdata.
- Misaligned conditions: half with addr[0]=1; word with addr[1:0]!=0; size=11.
- Misaligned request: no `dm` access. Next cycle resp_valid=1, resp_err=1, resp_rdata=0. State stays IDLE (latency 1).
- FSM states: IDLE, ACC, RMW_RD, RMW_WR.
  - IDLE -> ACC: any aligned load, or an aligned sw.
  - IDLE -> RMW_RD: aligned sb or sh.
- ACC, load:
  - dm_ctrl_r=1.
  - Select the byte/half lane from dm_rdata using addr[1:0] and BIG_ENDIAN, then extend it.
  - At the edge: resp_rdata <= extended value, resp_valid <= 1, state <= IDLE.
  - Response appears 2 cycles after accept.
- ACC, sw: dm_ctrl_w=1, dm_wdata=wdata. `dm` writes at the edge; resp_valid pulses the next cycle. Latency 2.
- RMW_RD: dm_ctrl_r=1. At the edge, merge wbuf <= dm_rdata with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]. Then go to RMW_WR.
- RMW_WR: dm_ctrl_w=1, dm_wdata=wbuf. Then resp_valid pulses and state returns to IDLE. Latency 3.
- dm_ctrl_r and dm_ctrl_w are never high together.
- dm_addr = {addr[ADDR_W-1:2],2'b00} in ACC, RMW_RD and RMW_WR; 0 in IDLE.
- resp_valid is a single-cycle pulse with no backpressure.
- resp_err and resp_rdata hold their values until the next response.
- req_ready is high during the cycle in which resp_valid is high, so back-to-back requests are allowed: the accept coincides with the previous response.
- Request inputs are ignored while not in IDLE.
- Reset mid-operation: a reset during RMW_RD aborts before any write, leaving memory unchanged. A reset during ACC or RMW_WR deasserts dm_ctrl_w asynchronously. No response is issued for the aborted request.

Optional Feature:
- MEM_LSU_ERRCNT_EN defined:
  - Adds output err_cnt [15:0], reset 0.
  - Increments by 1 on every resp_valid with resp_err, saturating at 16'hFFFF.
- MEM_LSU_ERRCNT_EN undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- sw addr=4 data=0x11223344, then lw addr=4 -> dm word 4 = 0x11223344; lw resp_rdata=0x11223344, resp_err=0; each response 2 cycles after its accept.
- With word 4 = 0x11223344 (BIG_ENDIAN=0):
  - lb addr=6 -> 0x00000022.
  - lh addr=6 -> 0x00001122.
  - Write 0x80 into byte 5 first; then lb addr=5 -> 0xFFFFFF80 and lbu addr=5 -> 0x00000080.
- sb addr=9 data=0xAB over word 8 = 0x00000080 -> dm word 8 = 0x0000AB80; resp 3 cycles after accept; ctrl_r then ctrl_w on consecutive cycles.
- lw addr=2, sh addr=3 and size=11 -> each gives resp_err=1 and resp_rdata=0 one cycle after accept; dm_ctrl_w and dm_ctrl_r stay 0. err_cnt=3 when MEM_LSU_ERRCNT_EN is defined.
- sh addr=0 data=0xBEEF, with rst_n pulled low during RMW_RD -> dm word 0 unchanged; no resp_valid; req_ready=1 after reset.
- Back-to-back: hold req_valid and issue lw 0, lw 4, lw 8 -> one resp_valid every 2 cycles, in order, with the correct data.
